// File: rtl/bpred_pkg.sv
// Shared types for the gshare branch predictor: 2-bit counter encoding,
// controller FSM states and the saturating counter update.
package bpred_pkg;

    typedef logic [1:0] ctr2_t;

    localparam ctr2_t CTR_SNT = 2'b00;
    localparam ctr2_t CTR_WNT = 2'b01;
    localparam ctr2_t CTR_WT  = 2'b10;
    localparam ctr2_t CTR_ST  = 2'b11;

    typedef enum logic {
        INIT,
        RUN
    } pht_state_t;

    // Counters clamp at both ends; they never wrap.
    function automatic ctr2_t sat_update(input ctr2_t ctr, input logic taken);
        ctr2_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                res = ctr + 2'b01;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                res = ctr - 2'b01;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bpred_ghr.sv
// Global history register: speculative shift on predict, restore from the
// resolved snapshot on mispredict (restore wins), frozen while hold_i is high.
module bpred_ghr
    import bpred_pkg::*;
#(
    parameter int HIST_W = 7
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              hold_i,
    input  logic              spec_valid_i,
    input  logic              spec_bit_i,
    input  logic              recover_valid_i,
    input  logic              recover_bit_i,
    input  logic [HIST_W-1:0] recover_hist_i,
    output logic [HIST_W-1:0] ghr_o
);

    logic [HIST_W-1:0] ghr_q;
    logic [HIST_W-1:0] ghr_d;
    logic              unused_recover_msb;

    // A mispredict replays history from the snapshot taken at predict time,
    // so any speculative shift in the same cycle belongs to a squashed path.
    always_comb begin
        ghr_d = ghr_q;
        if (!hold_i) begin
            if (recover_valid_i) begin
                ghr_d = {recover_hist_i[HIST_W-2:0], recover_bit_i};
            end else if (spec_valid_i) begin
                ghr_d = {ghr_q[HIST_W-2:0], spec_bit_i};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign ghr_o              = ghr_q;
    assign unused_recover_msb = recover_hist_i[HIST_W-1];

endmodule

// File: rtl/bpred_pht_ctrl.sv
// Gshare PHT controller: counter table, power-up INIT sweep, predict/train ports.
// Optional same-cycle train->predict forwarding with BPRED_PHT_BYPASS_EN.
module bpred_pht_ctrl
    import bpred_pkg::*;
#(
    parameter int IDX_W  = 7,
    parameter int HIST_W = 7
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              predict_valid,
    input  logic [IDX_W-1:0]  predict_pc,
    output logic              predict_ready,
    output logic              predict_taken,
    output logic [HIST_W-1:0] predict_history,
    input  logic              train_valid,
    input  logic              train_taken,
    input  logic              train_mispredicted,
    input  logic [IDX_W-1:0]  train_pc,
    input  logic [HIST_W-1:0] train_history,
    output logic              train_ready,
    output logic              init_busy
);

    localparam int DEPTH = 1 << IDX_W;

    pht_state_t        state_q;
    pht_state_t        state_d;
    logic [IDX_W-1:0]  init_ptr_q;
    logic [IDX_W-1:0]  init_ptr_d;
    ctr2_t             pht_q [DEPTH];

    logic [HIST_W-1:0] ghr;
    logic              run;
    logic [IDX_W-1:0]  pred_idx;
    logic [IDX_W-1:0]  train_idx;
    ctr2_t             pred_ctr;
    ctr2_t             train_ctr;
    ctr2_t             train_upd;
    logic              pred_bit;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    ctr2_t             wr_data;

    assign run       = (state_q == RUN);
    assign pred_idx  = predict_pc ^ IDX_W'(ghr);
    assign train_idx = train_pc ^ IDX_W'(train_history);
    assign pred_ctr  = pht_q[pred_idx];
    assign train_ctr = pht_q[train_idx];
    assign train_upd = sat_update(train_ctr, train_taken);

`ifdef BPRED_PHT_BYPASS_EN
    assign pred_bit = (train_valid && (train_idx == pred_idx)) ? train_upd[1] : pred_ctr[1];
`else
    assign pred_bit = pred_ctr[1];
`endif

    // INIT owns the single write port for the sweep; RUN hands it to training.
    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        wr_en         = 1'b0;
        wr_idx        = train_idx;
        wr_data       = train_upd;
        init_busy     = 1'b0;
        predict_ready = 1'b0;
        train_ready   = 1'b0;
        predict_taken = 1'b0;
        case (state_q)
            INIT: begin
                init_busy  = 1'b1;
                wr_en      = 1'b1;
                wr_idx     = init_ptr_q;
                wr_data    = CTR_WNT;
                init_ptr_d = init_ptr_q + IDX_W'(1);
                if (init_ptr_q == '1) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                predict_ready = 1'b1;
                train_ready   = 1'b1;
                predict_taken = pred_bit;
                wr_en         = train_valid;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q    <= INIT;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
        end
    end

    // Table contents are not reset; the INIT sweep establishes them.
    always_ff @(posedge clk) begin
        if (wr_en && !areset) begin
            pht_q[wr_idx] <= wr_data;
        end
    end

    bpred_ghr #(
        .HIST_W(HIST_W)
    ) u_ghr (
        .clk             (clk),
        .areset          (areset),
        .hold_i          (!run),
        .spec_valid_i    (predict_valid),
        .spec_bit_i      (pred_bit),
        .recover_valid_i (train_valid && train_mispredicted),
        .recover_bit_i   (train_taken),
        .recover_hist_i  (train_history),
        .ghr_o           (ghr)
    );

    assign predict_history = ghr;

endmodule

// File: tb/tb_bpred_pht_ctrl.sv
// Directed self-checking bench for bpred_pht_ctrl (IDX_W=7, HIST_W=7).
// Honours BPRED_PHT_BYPASS_EN for the same-index collision expectations.
module tb_bpred_pht_ctrl;

    logic       clk = 1'b0;
    logic       areset;
    logic       predict_valid;
    logic [6:0] predict_pc;
    logic       predict_ready;
    logic       predict_taken;
    logic [6:0] predict_history;
    logic       train_valid;
    logic       train_taken;
    logic       train_mispredicted;
    logic [6:0] train_pc;
    logic [6:0] train_history;
    logic       train_ready;
    logic       init_busy;

    int errors = 0;
    int checks = 0;

`ifdef BPRED_PHT_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    bpred_pht_ctrl #(
        .IDX_W  (7),
        .HIST_W (7)
    ) dut (
        .clk                (clk),
        .areset             (areset),
        .predict_valid      (predict_valid),
        .predict_pc         (predict_pc),
        .predict_ready      (predict_ready),
        .predict_taken      (predict_taken),
        .predict_history    (predict_history),
        .train_valid        (train_valid),
        .train_taken        (train_taken),
        .train_mispredicted (train_mispredicted),
        .train_pc           (train_pc),
        .train_history      (train_history),
        .train_ready        (train_ready),
        .init_busy          (init_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic pv, input logic [6:0] ppc,
                                 input logic tv, input logic tt, input logic tm,
                                 input logic [6:0] tpc, input logic [6:0] th);
        predict_valid      = pv;
        predict_pc         = ppc;
        train_valid        = tv;
        train_taken        = tt;
        train_mispredicted = tm;
        train_pc           = tpc;
        train_history      = th;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00);
    endtask

    task automatic trainOnce(input logic [6:0] pc, input logic [6:0] hist, input logic taken);
        applyStimulus(1'b0, 7'h00, 1'b1, taken, 1'b0, pc, hist);
        tick();
        idle();
    endtask

    task automatic predictCheck(input string tag, input logic [6:0] pc, input logic exp);
        applyStimulus(1'b0, pc, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00);
        checkOutput(tag, 32'(predict_taken), 32'(exp));
    endtask

    // Reset, optionally abort the sweep after abortAt cycles with a second
    // reset, then run the sweep with hostile predict/train traffic applied.
    task automatic resetSweep(input string tag, input int abortAt);
        int cnt;
        int bad;
        idle();
        areset = 1'b1;
        tick();
        checkOutput({tag, "_rst_busy"}, 32'(init_busy), 32'd1);
        checkOutput({tag, "_rst_pready"}, 32'(predict_ready), 32'd0);
        checkOutput({tag, "_rst_tready"}, 32'(train_ready), 32'd0);
        checkOutput({tag, "_rst_taken"}, 32'(predict_taken), 32'd0);
        checkOutput({tag, "_rst_hist"}, 32'(predict_history), 32'd0);
        areset = 1'b0;
        if (abortAt > 0) begin
            repeat (abortAt) tick();
            checkOutput({tag, "_mid_busy"}, 32'(init_busy), 32'd1);
            areset = 1'b1;
            tick();
            areset = 1'b0;
        end
        applyStimulus(1'b1, 7'h05, 1'b1, 1'b1, 1'b1, 7'h05, 7'h15);
        cnt = 0;
        bad = 0;
        while (init_busy === 1'b1 && cnt < 300) begin
            if (predict_ready !== 1'b0 || train_ready !== 1'b0 ||
                predict_taken !== 1'b0 || predict_history !== 7'h00) begin
                bad++;
            end
            tick();
            cnt++;
        end
        idle();
        checkOutput({tag, "_sweep_len"}, 32'(cnt), 32'd128);
        checkOutput({tag, "_init_quiet"}, 32'(bad), 32'd0);
        checkOutput({tag, "_run_busy"}, 32'(init_busy), 32'd0);
        checkOutput({tag, "_run_pready"}, 32'(predict_ready), 32'd1);
        checkOutput({tag, "_run_tready"}, 32'(train_ready), 32'd1);
        checkOutput({tag, "_run_hist"}, 32'(predict_history), 32'd0);
    endtask

    initial begin
        areset = 1'b0;
        idle();
        tick();

        // Test 1: reset, sweep length, every entry weakly not-taken.
        resetSweep("t1", 0);
        for (int p = 0; p < 128; p++) begin
            predictCheck($sformatf("t1_pc%0d", p), 7'(p), 1'b0);
        end

        // Test 2: saturate up and down on pc=5, history 0.
        trainOnce(7'h05, 7'h00, 1'b1);
        predictCheck("t2_up1", 7'h05, 1'b1);
        trainOnce(7'h05, 7'h00, 1'b1);
        predictCheck("t2_up2", 7'h05, 1'b1);
        trainOnce(7'h05, 7'h00, 1'b1);
        predictCheck("t2_up3_sat", 7'h05, 1'b1);
        trainOnce(7'h05, 7'h00, 1'b0);
        predictCheck("t2_dn1", 7'h05, 1'b1);
        trainOnce(7'h05, 7'h00, 1'b0);
        predictCheck("t2_dn2", 7'h05, 1'b0);
        trainOnce(7'h05, 7'h00, 1'b0);
        predictCheck("t2_dn3", 7'h05, 1'b0);
        trainOnce(7'h05, 7'h00, 1'b0);
        predictCheck("t2_dn4_sat", 7'h05, 1'b0);
        trainOnce(7'h05, 7'h00, 1'b1);
        predictCheck("t2_nowrap_a", 7'h05, 1'b0);
        trainOnce(7'h05, 7'h00, 1'b1);
        predictCheck("t2_nowrap_b", 7'h05, 1'b1);

        // Test 3: speculative GHR; entries 5,4,6 trained strong-taken.
        trainOnce(7'h05, 7'h00, 1'b1);
        trainOnce(7'h04, 7'h00, 1'b1);
        trainOnce(7'h04, 7'h00, 1'b1);
        trainOnce(7'h06, 7'h00, 1'b1);
        trainOnce(7'h06, 7'h00, 1'b1);
        applyStimulus(1'b1, 7'h05, 1'b0, 1'b0, 1'b0, 7'h00, 7'h00);
        checkOutput("t3_hist0", 32'(predict_history), 32'h00);
        checkOutput("t3_taken0", 32'(predict_taken), 32'd1);
        tick();
        checkOutput("t3_hist1", 32'(predict_history), 32'h01);
        checkOutput("t3_taken1", 32'(predict_taken), 32'd1);
        tick();
        checkOutput("t3_hist2", 32'(predict_history), 32'h03);
        checkOutput("t3_taken2", 32'(predict_taken), 32'd1);
        tick();
        idle();
        checkOutput("t3_hist_end", 32'(predict_history), 32'h07);

        // Test 4: mispredict recovery beats the same-cycle speculative shift.
        applyStimulus(1'b1, 7'h05, 1'b1, 1'b1, 1'b1, 7'h20, 7'h15);
        tick();
        idle();
        checkOutput("t4_recover", 32'(predict_history), 32'h2B);
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h00, 7'h15);
        tick();
        idle();
        checkOutput("t4_mispred_novalid", 32'(predict_history), 32'h2B);
        applyStimulus(1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 7'h7F, 7'h7F);
        tick();
        idle();
        checkOutput("t4_recover_nt", 32'(predict_history), 32'h7E);
        applyStimulus(1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 7'h7F, 7'h7F);
        tick();
        idle();
        checkOutput("t4_train_noghr", 32'(predict_history), 32'h7E);

        // Test 5: same-index collision; GHR=7E, pc 0x10 -> index 0x6E (01).
        applyStimulus(1'b0, 7'h10, 1'b1, 1'b1, 1'b0, 7'h10, 7'h7E);
        checkOutput("t5_collide", 32'(predict_taken), 32'(BYP));
        tick();
        idle();
        predictCheck("t5_next", 7'h10, 1'b1);
        applyStimulus(1'b1, 7'h11, 1'b1, 1'b1, 1'b0, 7'h11, 7'h7E);
        checkOutput("t5_collide_spec", 32'(predict_taken), 32'(BYP));
        tick();
        idle();
        checkOutput("t5_spec_hist", 32'(predict_history), 32'h7C | 32'(BYP));

        // Test 6a: reset in RUN after entry 5 reached strong-taken.
        resetSweep("t6a", 0);
        predictCheck("t6a_pc5", 7'h05, 1'b0);
        predictCheck("t6a_pc4", 7'h04, 1'b0);
        predictCheck("t6a_pc6", 7'h06, 1'b0);

        // Test 6b: reset at INIT cycle 50 restarts the full sweep.
        trainOnce(7'h05, 7'h00, 1'b1);
        resetSweep("t6b", 50);
        predictCheck("t6b_pc5", 7'h05, 1'b0);
        predictCheck("t6b_pc0", 7'h00, 1'b0);
        predictCheck("t6b_pc127", 7'h7F, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpred_pht_ctrl.md
Name: bpred_pht_ctrl

Overview:
Controller for a gshare-style pattern history table (PHT) built from 2-bit saturating counters.
- Owns the table, the global history register (GHR), the power-up initialisation sequencer and the arbitration between predict and train traffic.
- Sits between fetch (predict port) and the branch-resolution stage (train port).

Parameters:
IDX_W, 7, PHT index width; table holds 2**IDX_W two-bit counters.
HIST_W, 7, GHR width; must be <= IDX_W; zero-extended to IDX_W for hashing.

Ports:
clk  input  1  clock; all state updates on rising edge.
areset  input  1  reset; synchronous, active-high.
predict_valid  input  1  fetch requests a prediction this cycle.
predict_pc  input  IDX_W  branch PC index bits.
predict_ready  output  1  high when predictions are valid (RUN state).
predict_taken  output  1  prediction (MSB of indexed counter).
predict_history  output  HIST_W  GHR value used for this prediction; returned later on train_history.
train_valid  input  1  resolved branch update.
train_taken  input  1  actual outcome.
train_mispredicted  input  1  outcome differed from prediction; triggers GHR recovery.
train_pc  input  IDX_W  PC index of resolved branch.
train_history  input  HIST_W  GHR snapshot captured at predict time.
train_ready  output  1  high in RUN state; train beats with train_ready low are dropped.
init_busy  output  1  high while the INIT sweep runs.

Behaviour:
- FSM states INIT and RUN. areset forces INIT, init pointer = 0, GHR = 0. areset overrides everything, including a sweep in progress, which restarts from 0.
- INIT: one entry per cycle is written to 2'b01 (weakly not-taken), pointer increments. After writing entry 2**IDX_W-1, next state is RUN. The sweep takes exactly 2**IDX_W cycles.
- INIT outputs: init_busy=1, predict_ready=0, train_ready=0, predict_taken=0, predict_history=GHR. Predict/train inputs are ignored; the GHR is frozen.
- Reset-visible values in the first INIT cycle: init_busy=1, predict_ready=0, train_ready=0, predict_taken=0, predict_history=0.
- RUN outputs: init_busy=0, predict_ready=1, train_ready=1.
- Predict index = predict_pc XOR zero_ext(GHR).
  - predict_taken and predict_history are combinational, with zero latency.
  - On predict_valid, GHR <= {GHR[HIST_W-2:0], predict_taken} (speculative update).
- Train index = train_pc XOR zero_ext(train_history). On train_valid the counter updates at the clock edge:
  - taken: +1, saturating at 2'b11.
  - not taken: -1, saturating at 2'b00.
  - No wrap-around in either direction.
- Updated counter is visible to predict from the next cycle.
- On train_valid && train_mispredicted: GHR <= {train_history[HIST_W-2:0], train_taken}.
  - This recovery has priority over a same-cycle speculative predict update, which is discarded.
- train_mispredicted without train_valid is ignored.
- Same-cycle predict and train to the same index: predict reads the pre-update value (no bypass in the base build).
- Only one write port exists: INIT writes and train writes are mutually exclusive by state.

Optional Feature:
Macro: BPRED_PHT_BYPASS_EN.
- Defined: when train_valid and the train index equals the predict index in the same RUN cycle, predict_taken is the MSB of the post-update counter value.
  - The speculative GHR shift uses this bypassed bit, unless mispredict recovery overrides it.
- Undefined: no forwarding; the pre-update value is returned, as described above.

Decomposition:
- Package bpred_pkg holds:
  - typedef ctr2_t (2-bit counter);
  - constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11;
  - FSM enum pht_state_t {INIT, RUN};
  - a saturating-update function sat_update(ctr2_t, taken).
- One natural sub-module: bpred_ghr (GHR register with speculative shift and recovery priority).
- Table storage and the INIT sequencer stay in the top module.

Test Plan:
1. Reset/INIT:
   - Stimulus: areset high 1 cycle, IDX_W=7.
   - Response: init_busy=1 and both readies 0 for exactly 128 cycles; then readies=1 and every pc 0..127 with GHR=0 predicts taken=0.
2. Saturate up and down:
   - Stimulus: train pc=5, history=0, taken=1 three times; then taken=0 once; then taken=0 three more times.
   - Response: predict pc=5 (GHR=0) gives taken=1 after the first two trains; still 1 after the single not-taken (11->10); 0 after the next not-taken, staying at 00 with no wrap.
3. Speculative GHR:
   - Stimulus: from GHR=0, predict_valid on 3 consecutive cycles with pc trained to strong-taken.
   - Response: predict_history reads 7'h00, 7'h01, 7'h03; GHR ends at 7'h07.
4. Mispredict recovery priority:
   - Stimulus: same cycle, predict_valid=1 and train_valid=1, train_mispredicted=1, train_history=7'h15, train_taken=1.
   - Response: next-cycle predict_history = 7'h2B.
5. Same-index collision:
   - Stimulus: entry at 2'b01; train taken and predict the same index in the same cycle.
   - Response: predict_taken=0 without BPRED_PHT_BYPASS_EN, 1 with it; the next-cycle predict gives 1 in both builds.
6. Reset mid-INIT/mid-RUN:
   - Stimulus: areset at INIT cycle 50, or in RUN after training pc=5 to 11.
   - Response: full 128-cycle sweep restarts, GHR=0, pc=5 predicts 0 afterwards; train_valid during INIT has no effect.
